// File: rtl/bl_wl_bank_programmer_if.sv
// Bitstream word stream into the bl/wl bank programmer.
// The loader is the master and the programmer is the slave.
interface bl_wl_bank_programmer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/bl_wl_bank_programmer.sv
// Programs one tile's config cells: each DATA_W-bit word is placed on its group of bit lines,
// then that group's word lines are pulsed. Bit i of bl/wl addresses config cell i.
module bl_wl_bank_programmer #(
    parameter int NUM_BITS  = 158,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  start,
    bl_wl_bank_programmer_if.slave dq,
    output logic [NUM_BITS-1:0]   bl,
    output logic [NUM_BITS-1:0]   wl,
    output logic                  busy,
    output logic                  done
);
    localparam int NGRP  = (NUM_BITS + DATA_W - 1) / DATA_W;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int TMAX  = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int TMR_W = $clog2(TMAX + 1);

    localparam logic [GRP_W-1:0] LAST_GRP  = GRP_W'(NGRP - 1);
    localparam logic [TMR_W-1:0] SETUP_END = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_END = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_END  = TMR_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCEPT, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [GRP_W-1:0]    grp_q, grp_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_BITS-1:0] bl_q, bl_d;
    logic [NUM_BITS-1:0] wl_q, wl_d;
    logic                din_ready_q, din_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // grp_sel marks the cells of the current group; din_spread replicates the word across
    // every group so that masking with grp_sel lands din[j] on cell grp*DATA_W+j.
    logic [NUM_BITS-1:0] grp_sel;
    logic [NUM_BITS-1:0] din_spread;

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_cell
        assign grp_sel[i]    = (grp_q == GRP_W'(i / DATA_W));
        assign din_spread[i] = dq.din[i % DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        timer_d     = timer_q;
        bl_d        = bl_q;
        wl_d        = wl_q;
        din_ready_d = din_ready_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    grp_d   = '0;
                    timer_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (din_ready_q && dq.din_valid) begin
                    state_d     = S_SETUP;
                    din_ready_d = 1'b0;
                    bl_d        = din_spread & grp_sel;
                    timer_d     = '0;
                end else begin
                    din_ready_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (timer_q == SETUP_END) begin
                    state_d = S_PULSE;
                    timer_d = '0;
                    wl_d    = grp_sel;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_PULSE: begin
                if (timer_q == PULSE_END) begin
                    state_d = S_HOLD;
                    timer_d = '0;
                    wl_d    = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (timer_q == HOLD_END) begin
                    timer_d = '0;
                    bl_d    = '0;
                    if (grp_q == LAST_GRP) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCEPT;
                        grp_d   = grp_q + GRP_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                bl_d        = '0;
                wl_d        = '0;
                din_ready_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= S_IDLE;
            grp_q       <= '0;
            timer_q     <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            timer_q     <= timer_d;
            bl_q        <= bl_d;
            wl_q        <= wl_d;
            din_ready_q <= din_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bl           = bl_q;
    assign wl           = wl_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dq.din_ready = din_ready_q;
endmodule

// File: tb/tb_bl_wl_bank_programmer.sv
// Directed bench for bl_wl_bank_programmer: cycle table for single-word/backpressure timing,
// then full-tile scoreboard, restart from DONE and async reset during a pulse.
module tb_bl_wl_bank_programmer;
    localparam int NB = 158;
    localparam int DW = 8;

    logic          prog_clk = 1'b0;
    logic          pReset_n = 1'b0;
    logic          start    = 1'b0;
    logic [NB-1:0] bl, wl;
    logic          busy, done;

    bl_wl_bank_programmer_if #(.DATA_W(DW)) dif ();

    bl_wl_bank_programmer #(
        .NUM_BITS(NB), .DATA_W(DW), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) dut (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .start    (start),
        .dq       (dif),
        .bl       (bl),
        .wl       (wl),
        .busy     (busy),
        .done     (done)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          st;
        logic          vld;
        logic [7:0]    din;
        logic          rdy;
        logic          bsy;
        logic          dn;
        logic [NB-1:0] bl;
        logic [NB-1:0] wl;
    } vec_t;

    task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Expected bus image: byte b on group g, cells beyond the tile dropped.
    function automatic logic [NB-1:0] gv(input logic [7:0] b, input int g);
        logic [NB-1:0] v;
        v = '0;
        for (int j = 0; j < DW; j++)
            if (g * DW + j < NB) v[g * DW + j] = b[j];
        return v;
    endfunction

    function automatic vec_t mk(input logic st, input logic vld, input logic [7:0] din,
                                input logic rdy, input logic [NB-1:0] b, input logic [NB-1:0] w);
        vec_t r;
        r.st = st; r.vld = vld; r.din = din;
        r.rdy = rdy; r.bsy = 1'b1; r.dn = 1'b0; r.bl = b; r.wl = w;
        return r;
    endfunction

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n, words, bad, sb_bad;
        int            wcnt[NB];
        logic [NB-1:0] wl_prev;

        // Reset held with start/valid asserted must keep every output low.
        dif.din = 8'hFF; dif.din_valid = 1'b1; start = 1'b1;
        repeat (3) step();
        chk("rst_bl", bl, '0);
        chk("rst_wl", wl, '0);
        chk("rst_rdy", NB'(dif.din_ready), '0);
        chk("rst_busy", NB'(busy), '0);
        chk("rst_done", NB'(done), '0);
        start = 1'b0; dif.din_valid = 1'b0; dif.din = 8'h00;
        @(negedge prog_clk); pReset_n = 1'b1;
        step();

        // Word A5 into group 0, 5-cycle valid gap, word 3C into group 1 with stray start/valid.
        tbl[0]  = mk(1, 0, 8'h00, 0, '0, '0);
        tbl[1]  = mk(0, 1, 8'hA5, 1, '0, '0);
        tbl[2]  = mk(0, 1, 8'hA5, 0, gv(8'hA5, 0), '0);
        tbl[3]  = mk(0, 0, 8'h00, 0, gv(8'hA5, 0), gv(8'hFF, 0));
        tbl[4]  = mk(0, 0, 8'h00, 0, gv(8'hA5, 0), gv(8'hFF, 0));
        tbl[5]  = mk(0, 0, 8'h00, 0, gv(8'hA5, 0), '0);
        tbl[6]  = mk(0, 0, 8'h00, 0, '0, '0);
        tbl[7]  = mk(0, 0, 8'h00, 1, '0, '0);
        tbl[8]  = mk(0, 0, 8'h00, 1, '0, '0);
        tbl[9]  = mk(0, 0, 8'h00, 1, '0, '0);
        tbl[10] = mk(0, 0, 8'h00, 1, '0, '0);
        tbl[11] = mk(0, 0, 8'h00, 1, '0, '0);
        tbl[12] = mk(0, 1, 8'h3C, 0, gv(8'h3C, 1), '0);
        tbl[13] = mk(0, 1, 8'h77, 0, gv(8'h3C, 1), gv(8'hFF, 1));
        tbl[14] = mk(1, 1, 8'h77, 0, gv(8'h3C, 1), gv(8'hFF, 1));
        tbl[15] = mk(0, 0, 8'h00, 0, gv(8'h3C, 1), '0);
        tbl[16] = mk(0, 0, 8'h00, 0, '0, '0);

        for (int i = 0; i < 17; i++) begin
            start = tbl[i].st; dif.din_valid = tbl[i].vld; dif.din = tbl[i].din;
            step();
            chk($sformatf("vec%0d_bl", i), bl, tbl[i].bl);
            chk($sformatf("vec%0d_wl", i), wl, tbl[i].wl);
            chk($sformatf("vec%0d_ctl", i), NB'({dif.din_ready, busy, done}),
                NB'({tbl[i].rdy, tbl[i].bsy, tbl[i].dn}));
        end
        start = 1'b0; dif.din_valid = 1'b0;

        // Full tile of FF words, valid held high throughout.
        pReset_n = 1'b0; step(); pReset_n = 1'b1; step();
        for (int i = 0; i < NB; i++) wcnt[i] = 0;
        words = 0; sb_bad = 0; n = 0;
        dif.din = 8'hFF; dif.din_valid = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        wl_prev = wl;
        while (!done && n < 300) begin
            if (dif.din_ready && dif.din_valid) words++;
            step();
            n++;
            for (int i = 0; i < NB; i++)
                if (wl[i] && !wl_prev[i]) wcnt[i]++;
            if ((wl & ~bl) != '0) sb_bad++;
            wl_prev = wl;
        end
        bad = 0;
        for (int i = 0; i < NB; i++) if (wcnt[i] != 1) bad++;
        chk("full_done_cycles", NB'(n), NB'(120));
        chk("full_words", NB'(words), NB'(20));
        chk("full_cells_once", NB'(bad), '0);
        chk("full_last_cell", NB'(wcnt[NB-1]), NB'(1));
        chk("full_wl_without_bl", NB'(sb_bad), '0);
        chk("full_end_ctl", NB'({busy, done}), NB'(2'b01));
        repeat (3) step();
        chk("done_held", NB'({busy, done, dif.din_ready}), NB'(3'b010));
        chk("done_bus_idle", bl | wl, '0);

        // Start in DONE restarts from group 0.
        start = 1'b1; step(); start = 1'b0;
        chk("restart_ctl", NB'({busy, done}), NB'(2'b10));
        n = 0;
        while (wl == '0 && n < 50) begin step(); n++; end
        chk("restart_grp0_wl", wl, gv(8'hFF, 0));

        // Run to the group 3 pulse, then reset asynchronously mid-cycle.
        n = 0;
        while (wl !== gv(8'hFF, 3) && n < 200) begin step(); n++; end
        chk("reach_grp3_pulse", wl, gv(8'hFF, 3));
        #2 pReset_n = 1'b0;
        #1;
        chk("arst_wl", wl, '0);
        chk("arst_bl", bl, '0);
        chk("arst_ctl", NB'({busy, done, dif.din_ready}), '0);
        dif.din_valid = 1'b0;
        step();
        @(negedge prog_clk); pReset_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        dif.din = 8'h81; dif.din_valid = 1'b1;
        n = 0;
        while (wl == '0 && n < 50) begin step(); n++; end
        dif.din_valid = 1'b0;
        chk("post_rst_wl", wl, gv(8'hFF, 0));
        chk("post_rst_bl", bl, gv(8'h81, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
